// File: rtl/timer0_interrupt_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : timer0_interrupt_unit                                      |
// | Description : Timer0 interrupt flag register (TIFR) and request logic.   |
// |               Latches OCF0/TOV0 set strobes from the timer control unit, |
// |               masks them with TIMSK and SREG.I, and presents one         |
// |               prioritised interrupt request with its vector address.     |
// |               Flags clear on CPU acknowledge or software write-1-clear.  |
// | Ports       : sysClock          - system clock, rising edge              |
// |               reset             - synchronous active-high reset          |
// |               TIFR_write_enable - level set strobe from timer unit       |
// |               TIFR_set_data     - flag pattern from timer unit           |
// |               TIMSK             - interrupt mask register                |
// |               global_int_enable - SREG I bit                             |
// |               sw_write_enable   - CPU write to TIFR this cycle           |
// |               sw_write_data     - CPU write data, 1 clears a flag        |
// |               int_ack           - CPU accepts the pending request        |
// |               irq               - interrupt request                      |
// |               irq_vector        - vector word address while irq=1        |
// |               TIFR_output       - flag register readback                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module timer0_interrupt_unit #(
  parameter logic [7:0] COMP_VECTOR = 8'h14,
  parameter logic [7:0] OVF_VECTOR  = 8'h16,
  parameter int         OCF_BIT     = 1,
  parameter int         TOV_BIT     = 0
) (
  input  logic       sysClock,
  input  logic       reset,
  input  logic       TIFR_write_enable,
  input  logic [7:0] TIFR_set_data,
  input  logic [7:0] TIMSK,
  input  logic       global_int_enable,
  input  logic       sw_write_enable,
  input  logic [7:0] sw_write_data,
  input  logic       int_ack,
  output logic       irq,
  output logic [7:0] irq_vector,
  output logic [7:0] TIFR_output
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_strobe_hist;
  logic       r_ocf;
  logic       r_tov;
  logic       r_src_comp;      // 1: serviced source is COMP, 0: OVF
  logic       r_irq;
  logic [7:0] r_vector;

  logic       w_set_edge;
  logic       w_set_c;
  logic       w_set_o;
  logic       w_ack;
  logic       w_ocf_next;
  logic       w_tov_next;
  logic       w_pending_c;
  logic       w_pending_o;
  logic       w_req;
  logic       w_src_flag_next;
  logic       w_src_mask;
  logic       w_src_comp_next;
  logic       w_irq_next;
  logic [7:0] w_vector_next;
  logic [7:0] w_tifr;
  logic       w_unused_bits;

  // A held-high strobe must set only once so that a flag cleared while the
  // compare still matches does not immediately reappear.
  assign w_set_edge = TIFR_write_enable & ~r_strobe_hist;
  assign w_set_c    = w_set_edge & TIFR_set_data[OCF_BIT];
  assign w_set_o    = w_set_edge & TIFR_set_data[TOV_BIT];

  // Acknowledge only counts while a request is actually outstanding.
  assign w_ack = (r_state == REQUEST) & int_ack;

  // Set has priority over either clear source in the same cycle.
  assign w_ocf_next = w_set_c |
                      (r_ocf & ~((sw_write_enable & sw_write_data[OCF_BIT]) |
                                 (w_ack & r_src_comp)));
  assign w_tov_next = w_set_o |
                      (r_tov & ~((sw_write_enable & sw_write_data[TOV_BIT]) |
                                 (w_ack & ~r_src_comp)));

  assign w_pending_c = r_ocf & TIMSK[OCF_BIT];
  assign w_pending_o = r_tov & TIMSK[TOV_BIT];
  assign w_req       = global_int_enable & (w_pending_c | w_pending_o);

  // Withdrawal looks at the flag's next value so a same-cycle re-set keeps
  // the request alive.
  assign w_src_flag_next = r_src_comp ? w_ocf_next : w_tov_next;
  assign w_src_mask      = r_src_comp ? TIMSK[OCF_BIT] : TIMSK[TOV_BIT];

  always_comb begin
    w_state_next    = r_state;
    w_irq_next      = r_irq;
    w_vector_next   = r_vector;
    w_src_comp_next = r_src_comp;
    case (r_state)
      IDLE: begin
        w_irq_next    = 1'b0;
        w_vector_next = 8'h00;
        if (w_req) begin
          w_state_next    = REQUEST;
          w_irq_next      = 1'b1;
          w_src_comp_next = w_pending_c;
          w_vector_next   = w_pending_c ? COMP_VECTOR : OVF_VECTOR;
        end
      end
      REQUEST: begin
        if (int_ack) begin
          w_state_next  = HOLDOFF;
          w_irq_next    = 1'b0;
          w_vector_next = 8'h00;
        end else if (!w_src_flag_next || !w_src_mask || !global_int_enable) begin
          w_state_next  = IDLE;
          w_irq_next    = 1'b0;
          w_vector_next = 8'h00;
        end
      end
      HOLDOFF: begin
        w_state_next  = IDLE;
        w_irq_next    = 1'b0;
        w_vector_next = 8'h00;
      end
      default: begin
        w_state_next  = IDLE;
        w_irq_next    = 1'b0;
        w_vector_next = 8'h00;
      end
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_strobe_hist <= 1'b0;
      r_ocf         <= 1'b0;
      r_tov         <= 1'b0;
      r_src_comp    <= 1'b0;
      r_irq         <= 1'b0;
      r_vector      <= 8'h00;
    end else begin
      r_state       <= w_state_next;
      r_strobe_hist <= TIFR_write_enable;
      r_ocf         <= w_ocf_next;
      r_tov         <= w_tov_next;
      r_src_comp    <= w_src_comp_next;
      r_irq         <= w_irq_next;
      r_vector      <= w_vector_next;
    end
  end

  always_comb begin
    w_tifr          = 8'h00;
    w_tifr[OCF_BIT] = r_ocf;
    w_tifr[TOV_BIT] = r_tov;
  end

  // Only the OCF/TOV positions of the byte-wide inputs carry meaning.
  assign w_unused_bits = ^{TIFR_set_data, sw_write_data, TIMSK};

  assign irq         = r_irq;
  assign irq_vector  = r_vector;
  assign TIFR_output = w_tifr;

endmodule
`default_nettype wire

// File: tb/tb_timer0_interrupt_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_timer0_interrupt_unit                                   |
// | Description : Directed self-checking bench for timer0_interrupt_unit.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_timer0_interrupt_unit;

  logic       sysClock = 1'b0;
  logic       reset;
  logic       TIFR_write_enable;
  logic [7:0] TIFR_set_data;
  logic [7:0] TIMSK;
  logic       global_int_enable;
  logic       sw_write_enable;
  logic [7:0] sw_write_data;
  logic       int_ack;
  logic       irq;
  logic [7:0] irq_vector;
  logic [7:0] TIFR_output;

  int checks = 0;
  int errors = 0;

  timer0_interrupt_unit dut (
    .sysClock          (sysClock),
    .reset             (reset),
    .TIFR_write_enable (TIFR_write_enable),
    .TIFR_set_data     (TIFR_set_data),
    .TIMSK             (TIMSK),
    .global_int_enable (global_int_enable),
    .sw_write_enable   (sw_write_enable),
    .sw_write_data     (sw_write_data),
    .int_ack           (int_ack),
    .irq               (irq),
    .irq_vector        (irq_vector),
    .TIFR_output       (TIFR_output)
  );

  always #5 sysClock = ~sysClock;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks irq, irq_vector and TIFR_output together.
  task automatic check_all(input string tag, input logic exp_irq,
                           input logic [7:0] exp_vec, input logic [7:0] exp_tifr);
    check({tag, ".irq"},  {7'd0, irq}, {7'd0, exp_irq});
    check({tag, ".vec"},  irq_vector, exp_vec);
    check({tag, ".tifr"}, TIFR_output, exp_tifr);
  endtask

  initial begin
    reset = 1'b1;
    TIFR_write_enable = 1'b0;
    TIFR_set_data = 8'h00;
    TIMSK = 8'h00;
    global_int_enable = 1'b0;
    sw_write_enable = 1'b0;
    sw_write_data = 8'h00;
    int_ack = 1'b0;
    #1;
    tick();
    tick();
    check_all("reset", 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    tick();
    check_all("idle", 1'b0, 8'h00, 8'h00);

    // 1: compare flag raises request with COMP vector one edge after the flag
    TIMSK = 8'h02; global_int_enable = 1'b1;
    TIFR_write_enable = 1'b1; TIFR_set_data = 8'h02;
    tick();
    check_all("t1.flag", 1'b0, 8'h00, 8'h02);
    tick();
    check_all("t1.irq", 1'b1, 8'h14, 8'h02);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_all("t1.ack", 1'b0, 8'h00, 8'h00);
    tick();
    check_all("t1.hold_no_reset", 1'b0, 8'h00, 8'h00);
    TIFR_write_enable = 1'b0;
    tick();

    // 2: held strobe sets once; SW clear sticks until strobe re-rises
    TIMSK = 8'h00;
    TIFR_write_enable = 1'b1; TIFR_set_data = 8'h02;
    tick();
    check("t2.set", TIFR_output, 8'h02);
    tick();
    sw_write_enable = 1'b1; sw_write_data = 8'h02;
    tick();
    sw_write_enable = 1'b0; sw_write_data = 8'h00;
    check("t2.swclr", TIFR_output, 8'h00);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t2.held", TIFR_output, 8'h00);
    end
    TIFR_write_enable = 1'b0;
    tick();
    check("t2.low", TIFR_output, 8'h00);
    TIFR_write_enable = 1'b1;
    tick();
    check("t2.rerise", TIFR_output, 8'h02);

    // ack with no request outstanding must not touch the flags
    TIFR_write_enable = 1'b0;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_all("ack_idle", 1'b0, 8'h00, 8'h02);
    sw_write_enable = 1'b1; sw_write_data = 8'hFF;
    tick();
    sw_write_enable = 1'b0; sw_write_data = 8'h00;
    check("clr_all", TIFR_output, 8'h00);

    // 3: both pending, COMP first then OVF after the holdoff
    TIMSK = 8'h03;
    TIFR_write_enable = 1'b1; TIFR_set_data = 8'h03;
    tick();
    TIFR_write_enable = 1'b0;
    check_all("t3.flags", 1'b0, 8'h00, 8'h03);
    tick();
    check_all("t3.comp", 1'b1, 8'h14, 8'h03);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_all("t3.ack", 1'b0, 8'h00, 8'h01);
    tick();
    check_all("t3.holdoff", 1'b0, 8'h00, 8'h01);
    tick();
    check_all("t3.ovf", 1'b1, 8'h16, 8'h01);

    // 4: dropping I withdraws the OVF request, raising it re-requests
    global_int_enable = 1'b0;
    tick();
    check_all("t4.drop", 1'b0, 8'h00, 8'h01);
    tick();
    check_all("t4.off", 1'b0, 8'h00, 8'h01);
    global_int_enable = 1'b1;
    tick();
    check_all("t4.raise", 1'b1, 8'h16, 8'h01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_all("t4.ack", 1'b0, 8'h00, 8'h00);
    tick();

    // 5: SW clear coincident with a new set edge -> set wins
    TIMSK = 8'h00;
    TIFR_write_enable = 1'b1; TIFR_set_data = 8'h02;
    tick();
    TIFR_write_enable = 1'b0;
    tick();
    check("t5.pre", TIFR_output, 8'h02);
    TIFR_write_enable = 1'b1;
    sw_write_enable = 1'b1; sw_write_data = 8'h02;
    tick();
    sw_write_enable = 1'b0; sw_write_data = 8'h00;
    TIFR_write_enable = 1'b0;
    check("t5.setwins", TIFR_output, 8'h02);
    sw_write_enable = 1'b1; sw_write_data = 8'h02;
    tick();
    sw_write_enable = 1'b0; sw_write_data = 8'h00;
    check("t5.clr", TIFR_output, 8'h00);

    // 6: reset during REQUEST with a coincident ack
    TIMSK = 8'h02;
    TIFR_write_enable = 1'b1; TIFR_set_data = 8'h02;
    tick();
    tick();
    check_all("t6.req", 1'b1, 8'h14, 8'h02);
    reset = 1'b1; int_ack = 1'b1; TIFR_write_enable = 1'b0;
    tick();
    check_all("t6.reset", 1'b0, 8'h00, 8'h00);
    reset = 1'b0; int_ack = 1'b0;
    tick();
    check_all("t6.after", 1'b0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
